// File: rtl/snake_pkg.sv
// Shared encodings for the snake step sequencer and the food placer: directions, PS/2 make codes,
// position field layout {y[12:7], x[6:0]}, and the step FSM states.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;

  localparam int POS_W    = 13;
  localparam int POS_X_LO = 0;
  localparam int POS_X_HI = 6;
  localparam int POS_Y_LO = 7;
  localparam int POS_Y_HI = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RD_HEAD,
    ST_HEAD_CHK,
    ST_SH_RD,
    ST_SH_WR,
    ST_WR_HEAD,
    ST_DONE
  } state_t;

  // Up/down and left/right differ only in bit 0, so a reversal is an XOR of 01.
  function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
    return (a ^ b) == 2'b01;
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head position and wall detection for one step in a given direction.
// SNAKE_WRAP_EN: when defined, the playfield is a torus and wall is never flagged.
module snake_next_head
  import snake_pkg::*;
#(
  parameter int GRID_W = 64,
  parameter int GRID_H = 48
) (
  input  logic [POS_W-1:0] cur_pos,
  input  logic [1:0]       dir,
  output logic [POS_W-1:0] nxt_pos,
  output logic             wall
);

  localparam logic [6:0] GW = 7'(GRID_W);
  localparam logic [5:0] GH = 6'(GRID_H);

  logic [6:0] x;
  logic [5:0] y;

  always_comb begin
    x = cur_pos[POS_X_HI:POS_X_LO];
    y = cur_pos[POS_Y_HI:POS_Y_LO];
    case (dir)
      DIR_UP:   y = y - 6'd1;
      DIR_DOWN: y = y + 6'd1;
      DIR_LEFT: x = x - 7'd1;
      default:  x = x + 7'd1;
    endcase
`ifdef SNAKE_WRAP_EN
    // Stepping off either edge lands on the opposite visible edge.
    if (x == GW) x = 7'd0;
    else if (x == 7'd127) x = GW - 7'd1;
    if (y == GH) y = 6'd0;
    else if (y == 6'd63) y = GH - 6'd1;
    wall = 1'b0;
`else
    wall = (x >= GW) || (y >= GH);
`endif
    nxt_pos = {y, x};
  end

endmodule

// File: rtl/snake_step_ctrl.sv
// Per-tick snake sequencer over an external single-port segment RAM: head read, body shift, head write.
// A step takes 2*(shifts)+4 cycles; ticks while busy are dropped and flagged. SNAKE_WRAP_EN selects wrapping walls.
module snake_step_ctrl
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = 16,
  parameter int LEN_W    = 5,
  parameter int INIT_LEN = 4,
  parameter int GRID_W   = 64,
  parameter int GRID_H   = 48
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tick,
  input  logic                       init,
  input  logic                       pause,
  input  logic [7:0]                 key_code,
  input  logic [POS_W-1:0]           food_pos,
  output logic [$clog2(MAX_LEN)-1:0] seg_addr,
  output logic                       seg_we,
  output logic [POS_W-1:0]           seg_wdata,
  input  logic [POS_W-1:0]           seg_rdata,
  output logic [LEN_W-1:0]           length,
  output logic [1:0]                 direction,
  output logic                       busy,
  output logic                       ate,
  output logic                       died,
  output logic                       dead,
  output logic                       overrun
);

  localparam int AW = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] MAX_L  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] INIT_L = LEN_W'(INIT_LEN);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] idx;
  logic [POS_W-1:0] new_head;
  logic             eat, grow, coll, wall_hit;
  logic [1:0]       pend_dir;

  logic [POS_W-1:0] nh;
  logic             nh_wall;
  logic             hc_eat, hc_grow;
  logic [LEN_W-1:0] hc_start;
  logic [LEN_W-1:0] init_x;
  logic             key_vld;
  logic [1:0]       key_dir;
  logic             accept;

  snake_next_head #(
    .GRID_W(GRID_W),
    .GRID_H(GRID_H)
  ) u_next_head (
    .cur_pos(seg_rdata),
    .dir    (direction),
    .nxt_pos(nh),
    .wall   (nh_wall)
  );

  always_comb begin
    key_vld = 1'b1;
    key_dir = DIR_RIGHT;
    case (key_code)
      KEY_UP:    key_dir = DIR_UP;
      KEY_DOWN:  key_dir = DIR_DOWN;
      KEY_LEFT:  key_dir = DIR_LEFT;
      KEY_RIGHT: key_dir = DIR_RIGHT;
      default:   key_vld = 1'b0;
    endcase
  end

  assign accept   = (state == ST_IDLE) && tick && !pause && !dead && !init;
  assign hc_eat   = !nh_wall && (nh == food_pos);
  assign hc_grow  = hc_eat && (length < MAX_L);
  // Growing keeps the old tail, so one extra segment is shifted.
  assign hc_start = hc_grow ? length : length - 1'b1;
  assign init_x   = INIT_L - LEN_W'(1) - idx;

  always_comb begin
    state_nxt = state;
    seg_addr  = '0;
    seg_we    = 1'b0;
    seg_wdata = '0;
    ate       = 1'b0;
    died      = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_RD_HEAD;
      end
      ST_INIT: begin
        seg_addr  = idx[AW-1:0];
        seg_we    = 1'b1;
        seg_wdata = POS_W'(init_x);
        if (idx == '0) state_nxt = ST_DONE;
      end
      ST_RD_HEAD: begin
        state_nxt = ST_HEAD_CHK;
      end
      ST_HEAD_CHK: begin
        if (nh_wall) state_nxt = ST_DONE;
        else if (hc_start != '0) state_nxt = ST_SH_RD;
        else state_nxt = ST_WR_HEAD;
      end
      ST_SH_RD: begin
        seg_addr  = idx[AW-1:0] - AW'(1);
        state_nxt = ST_SH_WR;
      end
      ST_SH_WR: begin
        seg_addr  = idx[AW-1:0];
        seg_we    = 1'b1;
        seg_wdata = seg_rdata;
        state_nxt = (idx > LEN_W'(1)) ? ST_SH_RD : ST_WR_HEAD;
      end
      ST_WR_HEAD: begin
        seg_we    = 1'b1;
        seg_wdata = new_head;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        ate       = eat && !init;
        died      = (wall_hit || coll) && !init;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (init) state_nxt = ST_INIT;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      new_head  <= '0;
      eat       <= 1'b0;
      grow      <= 1'b0;
      coll      <= 1'b0;
      wall_hit  <= 1'b0;
      length    <= INIT_L;
      direction <= DIR_RIGHT;
      pend_dir  <= DIR_RIGHT;
      dead      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (key_vld && !is_reverse(key_dir, direction)) pend_dir <= key_dir;
      if (tick && state != ST_IDLE) overrun <= 1'b1;
      if (init) begin
        idx      <= INIT_L - LEN_W'(1);
        eat      <= 1'b0;
        grow     <= 1'b0;
        coll     <= 1'b0;
        wall_hit <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) direction <= pend_dir;
          end
          ST_INIT: begin
            idx <= idx - 1'b1;
            if (idx == '0) begin
              length    <= INIT_L;
              direction <= DIR_RIGHT;
              pend_dir  <= DIR_RIGHT;
              dead      <= 1'b0;
              overrun   <= 1'b0;
            end
          end
          ST_HEAD_CHK: begin
            new_head <= nh;
            eat      <= hc_eat;
            grow     <= hc_grow;
            wall_hit <= nh_wall;
            coll     <= 1'b0;
            idx      <= hc_start;
          end
          ST_SH_WR: begin
            if (seg_rdata == new_head) coll <= 1'b1;
            idx <= idx - 1'b1;
          end
          ST_DONE: begin
            if (grow) length <= length + 1'b1;
            if (wall_hit || coll) dead <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Bench for snake_step_ctrl: behavioural RAM plus a queue-based snake model, directed and random steps.
module tb_snake_step_ctrl;

  localparam int MAX_LEN  = 16;
  localparam int LEN_W    = 5;
  localparam int INIT_LEN = 4;
  localparam int GRID_W   = 64;
  localparam int GRID_H   = 48;
  localparam logic [12:0] FOOD_NONE = {6'd63, 7'd127};

  logic        clk, rst_n, tick, init, pause;
  logic [7:0]  key_code;
  logic [12:0] food_pos;
  logic [3:0]  seg_addr;
  logic        seg_we;
  logic [12:0] seg_wdata, seg_rdata;
  logic [4:0]  length;
  logic [1:0]  direction;
  logic        busy, ate, died, dead, overrun;

  int n_tests = 0;
  int n_fail  = 0;

  logic [12:0] mem [0:MAX_LEN-1];
  logic [12:0] m_snake [$];
  logic [1:0]  m_dir, m_pend;
  bit          m_dead;
  logic [7:0]  keys [5] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h1C};

  snake_step_ctrl #(
    .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .INIT_LEN(INIT_LEN), .GRID_W(GRID_W), .GRID_H(GRID_H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .init(init), .pause(pause),
    .key_code(key_code), .food_pos(food_pos),
    .seg_addr(seg_addr), .seg_we(seg_we), .seg_wdata(seg_wdata), .seg_rdata(seg_rdata),
    .length(length), .direction(direction), .busy(busy), .ate(ate), .died(died),
    .dead(dead), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (seg_we) mem[seg_addr] <= seg_wdata;
    seg_rdata <= mem[seg_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [1:0] opposite(input logic [1:0] d);
    case (d)
      2'd0: return 2'd1;
      2'd1: return 2'd0;
      2'd2: return 2'd3;
      default: return 2'd2;
    endcase
  endfunction

  function automatic void m_eval_key();
    logic [1:0] kd;
    bit v;
    v = 1'b1;
    kd = 2'd0;
    case (key_code)
      8'h75: kd = 2'd0;
      8'h72: kd = 2'd1;
      8'h6B: kd = 2'd2;
      8'h74: kd = 2'd3;
      default: v = 1'b0;
    endcase
    if (v && kd != opposite(m_dir)) m_pend = kd;
  endfunction

  function automatic void m_next(input logic [12:0] p, input logic [1:0] d,
                                 output logic [12:0] nh, output bit wall);
    int x, y;
    x = int'(p[6:0]);
    y = int'(p[12:7]);
    case (d)
      2'd0: y = y - 1;
      2'd1: y = y + 1;
      2'd2: x = x - 1;
      default: x = x + 1;
    endcase
`ifdef SNAKE_WRAP_EN
    x = (x + GRID_W) % GRID_W;
    y = (y + GRID_H) % GRID_H;
    wall = 1'b0;
`else
    wall = (x < 0) || (x >= GRID_W) || (y < 0) || (y >= GRID_H);
`endif
    nh = {6'(y), 7'(x)};
  endfunction

  function automatic void m_init();
    m_snake.delete();
    for (int k = 0; k < INIT_LEN; k++) m_snake.push_back({6'd0, 7'(INIT_LEN - 1 - k)});
    m_dir  = 2'd3;
    m_pend = 2'd3;
    m_dead = 1'b0;
    m_eval_key();
  endfunction

  function automatic void m_step(output int ecyc, output bit eate, output bit edied);
    logic [12:0] nh;
    bit wall, eat, grow, coll;
    int n;
    m_dir = m_pend;
    m_next(m_snake[0], m_dir, nh, wall);
    if (wall) begin
      ecyc = 3; eate = 1'b0; edied = 1'b1; m_dead = 1'b1;
    end else begin
      eat  = (nh == food_pos);
      grow = eat && (m_snake.size() < MAX_LEN);
      n    = grow ? m_snake.size() : m_snake.size() - 1;
      coll = 1'b0;
      for (int k = 0; k < n; k++) if (m_snake[k] == nh) coll = 1'b1;
      m_snake.push_front(nh);
      if (!grow) void'(m_snake.pop_back());
      ecyc = 2 * n + 4; eate = eat; edied = coll;
      if (coll) m_dead = 1'b1;
    end
    m_eval_key();
  endfunction

  function automatic int ram_diff();
    for (int k = 0; k < m_snake.size(); k++) if (mem[k] !== m_snake[k]) return k;
    return -1;
  endfunction

  // ---------------- drivers ----------------
  task automatic set_key(input logic [7:0] k);
    key_code = k;
    m_eval_key();
    @(negedge clk);
  endtask

  task automatic run_step(output int cyc, output int na, output int nd, output bit to);
    na = 0; nd = 0; cyc = 0;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++; na += int'(ate); nd += int'(died);
      @(negedge clk);
    end
    to = (busy === 1'b1);
  endtask

  task automatic run_init(output int cyc, output bit to);
    cyc = 0;
    @(negedge clk); init = 1'b1;
    @(negedge clk); init = 1'b0;
    while (busy === 1'b1 && cyc < 100) begin cyc++; @(negedge clk); end
    to = (busy === 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_tests++; if (length !== 5'd4) begin n_fail++; $display("FAIL reset_length: got %0d want 4", length); end
    n_tests++; if (direction !== 2'd3) begin n_fail++; $display("FAIL reset_dir: got %0d want 3", direction); end
    n_tests++; if ({busy, ate, died, dead, overrun, seg_we} !== 6'b0)
      begin n_fail++; $display("FAIL reset_flags: got %b want 000000", {busy, ate, died, dead, overrun, seg_we}); end
    n_tests++; if ({seg_addr, seg_wdata} !== 17'd0)
      begin n_fail++; $display("FAIL reset_bus: got addr %0d wdata %h want 0 0", seg_addr, seg_wdata); end
  endtask

  task automatic test_init();
    int cyc; bit to; int d;
    run_init(cyc, to); m_init();
    n_tests++; if (to || cyc !== 5) begin n_fail++; $display("FAIL init_busy: got %0d cycles (timeout %0d) want 5", cyc, to); end
    d = ram_diff();
    n_tests++; if (d !== -1) begin n_fail++; $display("FAIL init_ram: idx %0d got %h want %h", d, mem[d], m_snake[d]); end
    n_tests++; if (mem[3] !== 13'd0 || mem[0] !== 13'd3)
      begin n_fail++; $display("FAIL init_ends: got %h %h want 0003 0000", mem[0], mem[3]); end
    n_tests++; if (length !== 5'd4 || direction !== 2'd3)
      begin n_fail++; $display("FAIL init_state: got len %0d dir %0d want 4 3", length, direction); end
  endtask

  task automatic test_basic_step();
    int cyc, na, nd, ec, d; bit to, ea, ed;
    food_pos = FOOD_NONE;
    set_key(8'h74);
    m_step(ec, ea, ed);
    run_step(cyc, na, nd, to);
    n_tests++; if (to || cyc !== 10) begin n_fail++; $display("FAIL step_latency: got %0d want 10", cyc); end
    n_tests++; if (na !== 0 || nd !== 0) begin n_fail++; $display("FAIL step_pulses: got ate %0d died %0d want 0 0", na, nd); end
    d = ram_diff();
    n_tests++; if (d !== -1 || mem[0] !== 13'd4 || mem[3] !== 13'd1)
      begin n_fail++; $display("FAIL step_ram: idx %0d head %h want 0004", d, mem[0]); end
  endtask

  task automatic test_reversal();
    int cyc, na, nd, ec, d; bit to, ea, ed;
    set_key(8'h6B);
    m_step(ec, ea, ed);
    run_step(cyc, na, nd, to);
    n_tests++; if (direction !== 2'd3) begin n_fail++; $display("FAIL rev_dir: got %0d want 3", direction); end
    d = ram_diff();
    n_tests++; if (d !== -1 || mem[0] !== 13'd5) begin n_fail++; $display("FAIL rev_head: got %h want 0005", mem[0]); end
  endtask

  task automatic test_food();
    int cyc, na, nd, ec, d; bit to, ea, ed;
    run_init(cyc, to); m_init();
    set_key(8'h74);
    food_pos = {6'd0, 7'd4};
    m_step(ec, ea, ed);
    run_step(cyc, na, nd, to);
    food_pos = FOOD_NONE;
    n_tests++; if (na !== 1 || nd !== 0) begin n_fail++; $display("FAIL food_ate: got ate %0d died %0d want 1 0", na, nd); end
    n_tests++; if (length !== 5'd5) begin n_fail++; $display("FAIL food_len: got %0d want 5", length); end
    n_tests++; if (to || cyc !== 12) begin n_fail++; $display("FAIL food_latency: got %0d want 12", cyc); end
    d = ram_diff();
    n_tests++; if (d !== -1 || mem[4] !== 13'd0) begin n_fail++; $display("FAIL food_ram: idx %0d tail %h want 0000", d, mem[4]); end
  endtask

  task automatic test_wall();
    int cyc, na, nd, ec, d, bad; bit to, ea, ed;
    bad = 0;
    food_pos = FOOD_NONE;
    while (m_snake[0][6:0] != 7'd63 && bad == 0) begin
      m_step(ec, ea, ed);
      run_step(cyc, na, nd, to);
      if (to || cyc != ec || nd != 0) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL wall_walk: got %0d bad steps want 0", bad); end
    m_step(ec, ea, ed);
    run_step(cyc, na, nd, to);
`ifdef SNAKE_WRAP_EN
    n_tests++; if (nd !== 0 || mem[0] !== 13'd0) begin n_fail++; $display("FAIL wall_wrap: got died %0d head %h want 0 0000", nd, mem[0]); end
`else
    n_tests++; if (nd !== 1 || dead !== 1'b1) begin n_fail++; $display("FAIL wall_death: got died %0d dead %0d want 1 1", nd, dead); end
    n_tests++; if (to || cyc !== 3) begin n_fail++; $display("FAIL wall_latency: got %0d want 3", cyc); end
`endif
    d = ram_diff();
    n_tests++; if (d !== -1) begin n_fail++; $display("FAIL wall_ram: idx %0d got %h want %h", d, mem[d], m_snake[d]); end
  endtask

  task automatic test_dead_and_overrun();
    int cyc, na, nd, ec, d; bit to, ea, ed;
    if (m_dead) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      for (int k = 0; k < 3; k++) begin
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dead_tick: got busy %0d want 0", busy); end
        @(negedge clk);
      end
      n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL dead_overrun: got %0d want 0", overrun); end
    end
    run_init(cyc, to); m_init();
    n_tests++; if (dead !== 1'b0) begin n_fail++; $display("FAIL init_clear_dead: got %0d want 0", dead); end
    set_key(8'h72);
    m_step(ec, ea, ed);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      tick = (cyc == 3);
      @(negedge clk);
    end
    tick = 1'b0;
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %0d want 1", overrun); end
    n_tests++; if (cyc !== ec) begin n_fail++; $display("FAIL overrun_latency: got %0d want %0d", cyc, ec); end
    d = ram_diff();
    n_tests++; if (d !== -1) begin n_fail++; $display("FAIL overrun_ram: idx %0d got %h want %h", d, mem[d], m_snake[d]); end
    run_init(cyc, to); m_init();
    n_tests++; if (overrun !== 1'b0 || dead !== 1'b0)
      begin n_fail++; $display("FAIL init_clear_flags: got overrun %0d dead %0d want 0 0", overrun, dead); end
  endtask

  task automatic test_init_abort();
    int cyc, d;
    set_key(8'h75);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk);
    @(negedge clk); init = 1'b1;
    @(negedge clk); init = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin cyc++; @(negedge clk); end
    m_init();
    n_tests++; if (cyc !== 5) begin n_fail++; $display("FAIL abort_latency: got %0d want 5", cyc); end
    d = ram_diff();
    n_tests++; if (d !== -1 || length !== 5'd4 || direction !== 2'd3)
      begin n_fail++; $display("FAIL abort_state: idx %0d len %0d dir %0d want -1 4 3", d, length, direction); end
  endtask

  task automatic test_random();
    int cyc, na, nd, ec, d; bit to, ea, ed, w;
    logic [12:0] nh;
    logic [1:0] dir_before;
    for (int it = 0; it < 200; it++) begin
      set_key(keys[$urandom_range(0, 4)]);
      if (m_dead) begin
        run_init(cyc, to); m_init();
        n_tests++; if (to || cyc !== 5 || dead !== 1'b0)
          begin n_fail++; $display("FAIL rnd_init: got cycles %0d dead %0d want 5 0", cyc, dead); end
      end else if ($urandom_range(0, 7) == 0) begin
        dir_before = direction;
        pause = 1'b1;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        n_tests++; if (busy !== 1'b0 || direction !== dir_before)
          begin n_fail++; $display("FAIL rnd_pause: got busy %0d dir %0d want 0 %0d", busy, direction, dir_before); end
        pause = 1'b0;
      end else begin
        m_next(m_snake[0], m_pend, nh, w);
        food_pos = $urandom_range(0, 1) ? nh : {6'($urandom_range(0, GRID_H - 1)), 7'($urandom_range(0, GRID_W - 1))};
        m_step(ec, ea, ed);
        run_step(cyc, na, nd, to);
        n_tests++; if (to || cyc !== ec) begin n_fail++; $display("FAIL rnd_latency: it %0d got %0d want %0d", it, cyc, ec); end
        n_tests++; if (na !== int'(ea) || nd !== int'(ed))
          begin n_fail++; $display("FAIL rnd_pulses: it %0d got ate %0d died %0d want %0d %0d", it, na, nd, ea, ed); end
        n_tests++; if (int'(length) !== m_snake.size() || direction !== m_dir || dead !== m_dead)
          begin n_fail++; $display("FAIL rnd_state: it %0d got len %0d dir %0d dead %0d want %0d %0d %0d",
                                   it, length, direction, dead, m_snake.size(), m_dir, m_dead); end
        d = ram_diff();
        n_tests++; if (d !== -1) begin n_fail++; $display("FAIL rnd_ram: it %0d idx %0d got %h want %h", it, d, mem[d], m_snake[d]); end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < MAX_LEN; k++) mem[k] = 13'd0;
    rst_n = 1'b0; tick = 1'b0; init = 1'b0; pause = 1'b0;
    key_code = 8'h00; food_pos = FOOD_NONE;
    m_dir = 2'd3; m_pend = 2'd3; m_dead = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_init();
    test_basic_step();
    test_reversal();
    test_food();
    test_wall();
    test_dead_and_overrun();
    test_init_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
